// File: rtl/rr_arb_16_4bit.sv
// Round-robin arbiter/sequencer for a shared 16:1 x 4-bit mux: picks a requester, drives the
// mux select, registers the selected word and hands it downstream on a valid/ready handshake.
module rr_arb_16_4bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        arb_en,
  input  logic [3:0]  mux_out,
  output logic [3:0]  sel,
  output logic [3:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ack,
  output logic        busy
);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_grant = 2'd1;
  localparam logic [1:0] st_hold  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;

  logic [3:0] winner;
  logic       found;
  logic       hs;

  // First set request bit scanning upward from ptr, wrapping modulo 16.
  always_comb begin
    logic [3:0] idx;
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = 0; i < 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign hs = (state_q == st_hold) && valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      st_idle: begin
        if (arb_en && found) begin
          sel_d   = winner;
          state_d = st_grant;
        end
      end
      st_grant: begin
        // sel has been stable for a full cycle, so mux_out is settled here.
        data_d  = mux_out;
        valid_d = 1'b1;
        state_d = st_hold;
      end
      st_hold: begin
        if (hs) begin
          valid_d = 1'b0;
          ptr_d   = sel_q + 4'd1;
          state_d = st_idle;
        end
      end
      default: begin
        state_d = st_idle;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != st_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_idle;
      ptr_q   <= 4'd0;
      sel_q   <= 4'd0;
      data_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign ack       = hs ? (16'd1 << sel_q) : 16'd0;

endmodule

// File: tb/tb_rr_arb_16_4bit.sv
// Directed bench for rr_arb_16_4bit with a behavioural 16:1 mux driven from sel.
module tb_rr_arb_16_4bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        arb_en;
  logic [3:0]  mux_out;
  logic [3:0]  sel;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ack;
  logic        busy;

  logic [3:0]  a [16];
  int          total;
  int          bad;

  rr_arb_16_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .arb_en    (arb_en),
    .mux_out   (mux_out),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ack       (ack),
    .busy      (busy)
  );

  assign mux_out = a[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 16'h0;
    arb_en    = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) a[i] = 4'(i);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sel !== 4'd0) begin bad++; $display("FAIL reset_sel got=%h exp=0", sel); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 4'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ack !== 16'h0) begin bad++; $display("FAIL reset_ack got=%h exp=0", ack); end
  endtask

  task automatic test_single();
    do_reset();
    a[3] = 4'hA; out_ready = 1'b1; req = 16'h0008;
    tick();
    total++; if (sel !== 4'd3) begin bad++; $display("FAIL single_sel got=%0d exp=3", sel); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 4'hA)
      begin bad++; $display("FAIL single_data got=%b/%h exp=1/a", out_valid, out_data); end
    total++; if (ack !== 16'h0008) begin bad++; $display("FAIL single_ack got=%h exp=0008", ack); end
    tick();
    req = 16'h0018;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL single_after got=%b/%b exp=0/0", out_valid, busy); end
    tick();
    // ptr must now be 4, so 4 beats 3.
    total++; if (sel !== 4'd4) begin bad++; $display("FAIL single_ptr4 got=%0d exp=4", sel); end
  endtask

  task automatic test_fairness();
    logic [3:0] expi;
    int cyc;
    do_reset();
    out_ready = 1'b1;
    req = 16'hFFFF;
    for (int n = 0; n < 17; n++) begin
      expi = 4'(n % 16);
      cyc = 0;
      while (!out_valid && cyc < 10) begin tick(); cyc++; end
      total++; if (!out_valid) begin bad++; $display("FAIL rr_timeout n=%0d got=0 exp=1", n); end
      total++; if (sel !== expi) begin bad++; $display("FAIL rr_order n=%0d got=%0d exp=%0d", n, sel, expi); end
      total++; if (ack !== (16'd1 << expi) || out_data !== a[expi])
        begin bad++; $display("FAIL rr_ack n=%0d got=%h/%h exp=%h/%h", n, ack, out_data,
                              16'd1 << expi, a[expi]); end
      tick();
      req[expi] = 1'b0;
      tick();
      req[expi] = 1'b1;
    end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    out_ready = 1'b1;
    req = 16'h4000;
    tick(); tick();
    total++; if (ack !== 16'h4000) begin bad++; $display("FAIL wrap_serve14 got=%h exp=4000", ack); end
    tick();
    req = 16'h8001;
    tick();
    total++; if (sel !== 4'd15) begin bad++; $display("FAIL wrap_first got=%0d exp=15", sel); end
    tick();
    total++; if (ack !== 16'h8000) begin bad++; $display("FAIL wrap_ack15 got=%h exp=8000", ack); end
    tick();
    req = 16'h0001;
    cyc = 0;
    while (!out_valid && cyc < 10) begin tick(); cyc++; end
    total++; if (sel !== 4'd0 || ack !== 16'h0001)
      begin bad++; $display("FAIL wrap_second got=%0d/%h exp=0/0001", sel, ack); end
    tick();
    req = 16'h0003;
    tick();
    total++; if (sel !== 4'd1) begin bad++; $display("FAIL wrap_ptr1 got=%0d exp=1", sel); end
    tick(); tick();
    req = 16'h0;
  endtask

  task automatic test_backpressure();
    int cyc;
    int errs;
    do_reset();
    a[5] = 4'h7;
    out_ready = 1'b0;
    req = 16'h0020;
    cyc = 0;
    while (!out_valid && cyc < 10) begin tick(); cyc++; end
    total++; if (!out_valid) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
    errs = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) req[5] = 1'b0;
      if (c == 4) a[5] = 4'hC;
      #1;
      if (out_data !== 4'h7 || sel !== 4'd5 || out_valid !== 1'b1 || ack !== 16'h0) errs++;
      tick();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_stable got=%0d bad_cycles exp=0", errs); end
    out_ready = 1'b1;
    #1;
    total++; if (ack !== 16'h0020) begin bad++; $display("FAIL bp_ack got=%h exp=0020", ack); end
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL bp_done got=%b/%b exp=0/0", out_valid, busy); end
  endtask

  task automatic test_enable();
    int cyc;
    int errs;
    do_reset();
    arb_en = 1'b0;
    out_ready = 1'b0;
    req = 16'h0100;
    repeat (5) tick();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || sel !== 4'd0)
      begin bad++; $display("FAIL en_gate got=%b/%b/%0d exp=0/0/0", busy, out_valid, sel); end
    arb_en = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 10) begin tick(); cyc++; end
    total++; if (sel !== 4'd8 || !out_valid)
      begin bad++; $display("FAIL en_grant got=%0d/%b exp=8/1", sel, out_valid); end
    arb_en = 1'b0;
    req = 16'h0101;
    tick();
    out_ready = 1'b1;
    #1;
    total++; if (ack !== 16'h0100) begin bad++; $display("FAIL en_hold_ack got=%h exp=0100", ack); end
    tick();
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      if (busy !== 1'b0 || out_valid !== 1'b0 || ack !== 16'h0) errs++;
      tick();
    end
    total++; if (errs != 0) begin bad++; $display("FAIL en_no_regrant got=%0d bad_cycles exp=0", errs); end
    req = 16'h0;
    arb_en = 1'b1;
  endtask

  task automatic test_async_reset();
    int cyc;
    out_ready = 1'b0;
    req = 16'h0400;
    cyc = 0;
    while (!out_valid && cyc < 10) begin tick(); cyc++; end
    total++; if (sel !== 4'd10 || !out_valid)
      begin bad++; $display("FAIL ar_setup got=%0d/%b exp=10/1", sel, out_valid); end
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || sel !== 4'd0 || ack !== 16'h0 || busy !== 1'b0)
      begin bad++; $display("FAIL ar_immediate got=%b/%0d/%h/%b exp=0/0/0/0", out_valid, sel, ack, busy); end
    tick();
    rst_n = 1'b1;
    req = 16'h0401;
    tick();
    // Stale ptr (9) would pick 10; a cleared ptr picks 0.
    total++; if (sel !== 4'd0) begin bad++; $display("FAIL ar_resume got=%0d exp=0", sel); end
    req = 16'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_backpressure();
    test_enable();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_16_4bit.md
# rr_arb_16_4bit

Round-robin arbiter and sequencer for the 16:1 4-bit multiplexer datapath. It shares the 4-bit mux output among 16 requesters, drives the mux select, and registers the selected word. It presents that word downstream on a valid/ready handshake and returns a one-hot acknowledge to the served requester. It sits between the requester array and the downstream consumer, with the mux instance as its datapath.

## Interface
- N_REQ, 16, number of requesters; fixed at 16, not overridable.
- DW, 4, data width of each mux input and of out_data.

- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  16  per-requester request level; bit i requests service for mux input a_i.
- arb_en  input  1  arbitration enable; low blocks new grants only.
- mux_out  input  4  combinational output of the 16:1 mux, from the select driven by sel.
- sel  output  4  mux select, equal to the current grant index.
- out_data  output  4  registered word captured from mux_out.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data when high with out_valid.
- ack  output  16  one-hot, combinational; bit sel is high in the handshake cycle.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, GRANT, HOLD. Encoding is free.
- Round-robin pointer ptr[3:0]. Search order is ptr, ptr+1, …, 15, 0, …, ptr-1, modulo 16.
- IDLE:
  - If arb_en=1 and req≠0, the winner is the first set bit in search order.
  - sel←winner; next state GRANT.
  - Otherwise stay in IDLE with sel unchanged.
- GRANT:
  - Hold sel for one cycle so mux_out settles.
  - out_data←mux_out, out_valid←1; next state HOLD.
- HOLD:
  - sel and out_data are held stable.
  - When out_valid=1 and out_ready=1: ack[sel]=1 that cycle, out_valid←0, ptr←sel+1 (15 wraps to 0), next state IDLE.
  - Otherwise stay in HOLD.
- ack is all-zero in every other cycle. At most one ack bit is high at any time.
- A grant is committed once taken. Deasserting req[sel] during GRANT or HOLD has no effect; the captured word is still delivered and acked.
- arb_en=0 during GRANT or HOLD has no effect; the transfer completes and then no new grant is issued.
- Requesters must drop req on the cycle after ack. A req still high after ack is treated as a new request and competes at its new, lowest priority.
- ptr does not change on a grant, only on a completed handshake.

## Timing
- Reset values (asynchronous, immediate on rst_n=0): state IDLE, ptr 0, sel 0, out_data 0, out_valid 0, busy 0, ack 0.
- Reset mid-transfer discards the in-flight word with no ack.
- Latency, with req sampled at edge E0 in IDLE:
  - after E0: sel=winner, busy=1.
  - after E1: out_valid=1 and out_data=mux_out as sampled at E1.
- Handshake at edge Ek: ack is high in the cycle before Ek; after Ek, out_valid=0 and state is IDLE.
- Minimum of 3 cycles per transfer, for a sustained 1 word per 3 cycles with out_ready held high.
- out_valid, once high, stays high and out_data stays stable until the handshake (no retraction).
- busy = (state ≠ IDLE), registered.

## Test plan
- Single request: reset, req=16'h0008, a3=4'hA, out_ready=1.
  - Required: sel=3 one cycle later, out_valid=1 with out_data=4'hA two cycles later, ack=16'h0008 in that cycle, ptr=4.
- Round-robin fairness: req=16'hFFFF held, with each requester dropping its bit after ack and re-raising it one cycle later.
  - Required: grant order 0,1,2,…,15,0; no index is served twice before all have been served once.
- Wrap-around: ptr=15 (after serving 14), req=16'h8001.
  - Required: 15 is granted first, then 0; ptr goes 15→0→1.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises, with req[sel] dropped and a5 changed mid-hold.
  - Required: out_data, sel and out_valid are stable for all 10 cycles and ack=0.
  - Required: ack pulses in the cycle out_ready goes to 1.
- Enable gating: arb_en=0 with req=16'h0100.
  - Required: stays IDLE, busy=0.
  - Drop arb_en during HOLD: the current transfer still completes and acks, and no further grant is issued.
- Async reset mid-transfer: assert rst_n=0 between clock edges while in HOLD.
  - Required: out_valid=0, sel=0, ack=0 immediately; after release, arbitration resumes from ptr=0.
